nvram_backup: RTL and testbench
===============================

NVRAM_BACKUP -- requirements
Module: nvram_backup

Interface
REQ-001 SECT_BITS, 4, log2 of backup size in 512-byte sectors; 4 gives 16 sectors, 8 KB.
REQ-002 AUTOSAVE_CYC, 0, idle clk_sys cycles after the last NVRAM write before an automatic save; 0 disables autosave.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 img_mounted  in  1  save-image mount strobe; a rising edge with img_size != 0 arms the backup.
REQ-006 img_size  in  32  mounted image size in bytes.
REQ-007 save_req  in  1  manual save request, acted on at its rising edge.
REQ-008 dl_start  in  1  ROM download active, acted on at its rising edge.
REQ-009 nv_wr  in  1  core NVRAM write strobe, one cycle per byte.
REQ-010 sd_lba  out  32  sector address presented to the SD interface.
REQ-011 sd_rd  out  1  sector read request.
REQ-012 sd_wr  out  1  sector write request.
REQ-013 sd_ack  in  1  SD interface acknowledge, high for the whole sector transfer.
REQ-014 bk_ena  out  1  backup armed.
REQ-015 busy  out  1  transfer in progress.
REQ-016 dirty  out  1  NVRAM modified since the last save or load.
REQ-017 bk_reset  out  1  one-cycle core reset pulse after a completed load.

Function
REQ-018 Sector limit:
- NMAX = 2^SECT_BITS.
- A load transfers NL = min(NMAX, ceil(img_size/512)) sectors.
- A save always transfers NMAX sectors.
REQ-019 States: IDLE, REQ, XFER.
- IDLE -> REQ when a load or save is started: drive sd_lba to the start sector; assert sd_rd (load) or sd_wr (save).
- REQ -> XFER on the sd_ack rising edge: clear sd_rd and sd_wr in that same cycle.
- XFER, on the sd_ack falling edge, if more sectors remain: sd_lba+1, reassert the request, go to REQ.
- XFER, on the sd_ack falling edge, after the last sector: go to IDLE.
REQ-020 After the last sector of a load: bk_reset high for exactly one cycle, dirty cleared.
REQ-021 busy = (state != IDLE).
REQ-022 sd_lba upper bits [31:SECT_BITS] are always 0.
REQ-023 Mount rising edge with img_size != 0:
- set bk_ena;
- queue a load.
REQ-024 Mount rising edge with img_size == 0: ignored.
REQ-025 save_req rising edge while bk_ena = 1 queues a save; while bk_ena = 0 it is ignored.
REQ-026 Queues are one-deep flags, pend_load and pend_save; a second request of the same kind while its flag is set is merged.
REQ-027 In IDLE, pend_load has priority over pend_save. A request arriving in the same cycle is queued and starts on the next cycle.
REQ-028 Starting a load clears pend_save.
REQ-029 Starting a save clears pend_save and dirty.
REQ-030 nv_wr sets dirty. When nv_wr and the start of a save coincide, set wins, so dirty = 1 after that cycle. Writes during a save leave dirty = 1 when the save ends.
REQ-031 Autosave (AUTOSAVE_CYC != 0):
- Idle counter cleared by nv_wr.
- Otherwise it increments while dirty = 1, saturating at AUTOSAVE_CYC.
- When it reaches AUTOSAVE_CYC with bk_ena = 1, state IDLE and no pending load: queue a save and clear the counter.
REQ-032 dl_start rising edge:
- clear bk_ena, pend_load and pend_save;
- an active transfer finishes its current sector; on that sd_ack falling edge it goes to IDLE with no further request and no bk_reset.
REQ-033 sd_ack rising edge seen in IDLE: ignored. sd_rd and sd_wr are never high together.

Reset
REQ-034 Synchronous reset, regardless of state:
- state IDLE;
- sd_rd, sd_wr, bk_ena, busy, dirty, bk_reset, pend_load, pend_save = 0;
- sd_lba = 0; idle counter = 0.
REQ-035 Reset mid-transfer drops the request in the same cycle. No bk_reset pulse is produced for an aborted load.
REQ-036 Edge-detect registers reset to 0. An input already high at reset release is therefore taken as a rising edge on the next cycle.

Verification
REQ-037 Mount, img_size = 8192, SECT_BITS = 4, ack model 3 cycles high and 2 cycles low:
- 16 reads, lba 0..15;
- bk_reset pulses once, one cycle after the 16th ack falls;
- dirty = 0.
REQ-038 Mount, img_size = 1000: exactly 2 reads (lba 0, 1), then bk_reset.
REQ-039 After a load, nv_wr once, then save_req:
- 16 writes, lba 0..15, dirty = 0 at the end;
- repeat with nv_wr during sector 5: dirty = 1 at the end.
REQ-040 AUTOSAVE_CYC = 100, nv_wr at cycle T with no later writes:
- sd_wr asserts at about T+100 (within 2 cycles);
- a second nv_wr at T+50 delays it to about T+150.
REQ-041 Mount and save_req in the same cycle: the load runs first, then 16 writes.
REQ-042 Abort cases:
- dl_start during sector 3 of a save: the sector completes, then no further requests, bk_ena = 0, and a later save_req is ignored;
- reset during a load: sd_rd = 0 the next cycle and no bk_reset pulse.

Source files
------------

// File: rtl/nvram_backup.sv
// NVRAM backup sequencer: loads the save image from SD after a mount and writes
// it back on manual request or after an idle period following core writes.
//
//   state  | meaning
//   S_IDLE | no transfer; pending load/save requests are started from here
//   S_REQ  | sd_rd or sd_wr asserted, waiting for the SD side to acknowledge
//   S_XFER | sector moving (sd_ack high), waiting for sd_ack to fall
module nvram_backup #(
  parameter int SECT_BITS    = 4,
  parameter int AUTOSAVE_CYC = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        save_req,
  input  logic        dl_start,
  input  logic        nv_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic        bk_ena,
  output logic        busy,
  output logic        dirty,
  output logic        bk_reset
);

  localparam int NS_W  = SECT_BITS + 1;
  localparam int CNT_W = (AUTOSAVE_CYC > 0) ? $clog2(AUTOSAVE_CYC + 1) : 1;
  localparam logic [NS_W-1:0]  NMAX    = NS_W'(1 << SECT_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(AUTOSAVE_CYC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t                 state_q, state_d;
  logic [SECT_BITS-1:0]   lba_q, lba_d;
  logic [NS_W-1:0]        nsec_q, nsec_d;
  logic [NS_W-1:0]        nl_q, nl_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_nxt;
  logic rd_q, rd_d, wr_q, wr_d, is_load_q, is_load_d, abort_q, abort_d;
  logic bk_ena_q, bk_ena_d, dirty_q, dirty_d, bk_reset_q, bk_reset_d;
  logic pend_load_q, pend_load_d, pend_save_q, pend_save_d;
  logic keep_save_q, keep_save_d;
  logic mount_q, mount_d, save_q, save_d, dl_q, dl_d, ack_q, ack_d;

  logic mount_rise, save_rise, dl_rise, ack_rise, ack_fall;
  logic mount_ok, save_ok, last_sect;
  logic [23:0]     size_sect;
  logic [NS_W-1:0] nl_new;

  assign mount_rise = img_mounted & ~mount_q;
  assign save_rise  = save_req & ~save_q;
  assign dl_rise    = dl_start & ~dl_q;
  assign ack_rise   = sd_ack & ~ack_q;
  assign ack_fall   = ~sd_ack & ack_q;
  assign mount_ok   = mount_rise && (img_size != 32'd0);
  // Arming in the same cycle counts, so a save requested together with the mount is honoured.
  assign save_ok    = save_rise && (bk_ena_q || mount_ok);

  // Rounded-up sector count of the image, capped to the backup size.
  assign size_sect = 24'(({1'b0, img_size} + 33'd511) >> 9);
  assign nl_new    = (size_sect >= 24'(1 << SECT_BITS)) ? NMAX : size_sect[NS_W-1:0];
  assign last_sect = (({1'b0, lba_q} + NS_W'(1)) == nsec_q);

  // Next-state, request queueing, dirty tracking and autosave timer.
  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    nsec_d      = nsec_q;
    nl_d        = nl_q;
    cnt_d       = cnt_q;
    cnt_nxt     = cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    is_load_d   = is_load_q;
    abort_d     = abort_q;
    bk_ena_d    = bk_ena_q;
    dirty_d     = dirty_q;
    bk_reset_d  = 1'b0;
    pend_load_d = pend_load_q;
    pend_save_d = pend_save_q;
    keep_save_d = keep_save_q;
    mount_d     = img_mounted;
    save_d      = save_req;
    dl_d        = dl_start;
    ack_d       = sd_ack;

    unique case (state_q)
      S_IDLE: begin
        if (!dl_rise && pend_load_q) begin
          state_d     = S_REQ;
          lba_d       = '0;
          rd_d        = 1'b1;
          nsec_d      = nl_q;
          is_load_d   = 1'b1;
          pend_load_d = 1'b0;
          // A load replaces NVRAM, so older save requests are dropped.
          if (!keep_save_q) pend_save_d = 1'b0;
          keep_save_d = 1'b0;
        end else if (!dl_rise && pend_save_q) begin
          state_d     = S_REQ;
          lba_d       = '0;
          wr_d        = 1'b1;
          nsec_d      = NMAX;
          is_load_d   = 1'b0;
          pend_save_d = 1'b0;
          dirty_d     = 1'b0;
        end
      end
      S_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (ack_fall) begin
          if (abort_q || dl_rise || last_sect) begin
            state_d = S_IDLE;
            abort_d = 1'b0;
            if (is_load_q && last_sect && !abort_q && !dl_rise) begin
              bk_reset_d = 1'b1;
              dirty_d    = 1'b0;
            end
          end else begin
            lba_d   = lba_q + SECT_BITS'(1);
            rd_d    = is_load_q;
            wr_d    = ~is_load_q;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (AUTOSAVE_CYC != 0) begin
      if (nv_wr) begin
        cnt_d = '0;
      end else begin
        cnt_nxt = (dirty_q && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
        if (cnt_nxt == CNT_MAX && dirty_q && bk_ena_q && state_q == S_IDLE &&
            !pend_load_q && !pend_save_q) begin
          pend_save_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
    end

    if (mount_ok) begin
      bk_ena_d    = 1'b1;
      pend_load_d = 1'b1;
      nl_d        = nl_new;
    end
    if (save_ok) begin
      pend_save_d = 1'b1;
      if (mount_ok) keep_save_d = 1'b1;
    end

    if (nv_wr) dirty_d = 1'b1;

    if (dl_rise) begin
      bk_ena_d    = 1'b0;
      pend_load_d = 1'b0;
      pend_save_d = 1'b0;
      keep_save_d = 1'b0;
      if (state_d != S_IDLE) abort_d = 1'b1;
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lba_q       <= '0;
      nsec_q      <= '0;
      nl_q        <= '0;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      is_load_q   <= 1'b0;
      abort_q     <= 1'b0;
      bk_ena_q    <= 1'b0;
      dirty_q     <= 1'b0;
      bk_reset_q  <= 1'b0;
      pend_load_q <= 1'b0;
      pend_save_q <= 1'b0;
      keep_save_q <= 1'b0;
      mount_q     <= 1'b0;
      save_q      <= 1'b0;
      dl_q        <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      nsec_q      <= nsec_d;
      nl_q        <= nl_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      is_load_q   <= is_load_d;
      abort_q     <= abort_d;
      bk_ena_q    <= bk_ena_d;
      dirty_q     <= dirty_d;
      bk_reset_q  <= bk_reset_d;
      pend_load_q <= pend_load_d;
      pend_save_q <= pend_save_d;
      keep_save_q <= keep_save_d;
      mount_q     <= mount_d;
      save_q      <= save_d;
      dl_q        <= dl_d;
      ack_q       <= ack_d;
    end
  end

  assign sd_lba   = {{(32-SECT_BITS){1'b0}}, lba_q};
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;
  assign bk_ena   = bk_ena_q;
  assign busy     = (state_q != S_IDLE);
  assign dirty    = dirty_q;
  assign bk_reset = bk_reset_q;

endmodule

// File: tb/tb_nvram_backup.sv
// Bench for nvram_backup: an SD responder logs every sector request; each test
// compares the log and status outputs against sector lists derived from image size.
module tb_nvram_backup;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic        img_mounted, save_req, dl_start, nv_wr, sd_ack;
  logic [31:0] img_size, sd_lba;
  logic        sd_rd, sd_wr, bk_ena, busy, dirty, bk_reset;

  logic        a_mounted, a_save, a_dl, a_nvwr, a_ack;
  logic [31:0] a_size, a_lba;
  logic        a_rd, a_wr, a_bk_ena, a_busy, a_dirty, a_bk_reset;

  nvram_backup #(.SECT_BITS(4), .AUTOSAVE_CYC(0)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .save_req(save_req), .dl_start(dl_start), .nv_wr(nv_wr), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .bk_ena(bk_ena), .busy(busy),
    .dirty(dirty), .bk_reset(bk_reset));

  nvram_backup #(.SECT_BITS(4), .AUTOSAVE_CYC(100)) dut_as (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(a_mounted), .img_size(a_size),
    .save_req(a_save), .dl_start(a_dl), .nv_wr(a_nvwr), .sd_lba(a_lba),
    .sd_rd(a_rd), .sd_wr(a_wr), .sd_ack(a_ack), .bk_ena(a_bk_ena), .busy(a_busy),
    .dirty(a_dirty), .bk_reset(a_bk_reset));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int txn_op[$];
  int txn_lba[$];
  int bk_cyc[$];
  int last_fall = -1;
  bit rand_ack = 1'b0;
  bit both_seen = 1'b0;
  bit model_dirty = 1'b0;
  bit a_wr_seen = 1'b0;
  int a_wr_cyc = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // SD responder for the main instance: logs each request, then acks it.
  initial begin : resp
    int dly, hi, lo;
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (sd_rd && sd_wr) both_seen = 1'b1;
      if (sd_rd || sd_wr) begin
        txn_op.push_back(sd_wr ? 1 : 0);
        txn_lba.push_back(int'(sd_lba));
        if (rand_ack) begin
          dly = $urandom_range(0, 2); hi = $urandom_range(1, 4); lo = $urandom_range(1, 3);
        end else begin
          dly = 0; hi = 3; lo = 2;
        end
        repeat (dly) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (hi) @(negedge clk_sys);
        sd_ack = 1'b0;
        last_fall = cyc;
        repeat (lo - 1) @(negedge clk_sys);
      end
    end
  end

  // Fixed-timing responder for the autosave instance.
  initial begin
    a_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (a_rd || a_wr) begin
        a_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        a_ack = 1'b0;
      end
    end
  end

  // Record bk_reset pulses and the first autosave write request.
  always @(negedge clk_sys) begin
    if (bk_reset) bk_cyc.push_back(cyc);
    if (a_wr && !a_wr_seen) begin
      a_wr_seen = 1'b1;
      a_wr_cyc  = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_quiet(input bit sel, input int budget, output bit ok);
    int q;
    q = 0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (sel ? !a_busy : !busy) q++; else q = 0;
      if (q >= 8) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_count(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (txn_lba.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk_sys);
    end
  endtask

  task automatic clear_log;
    txn_op.delete(); txn_lba.delete(); bk_cyc.delete();
  endtask

  task automatic mount(input int unsigned size);
    img_size = size; img_mounted = 1'b1; tick(1); img_mounted = 1'b0;
  endtask

  task automatic pulse_save;
    save_req = 1'b1; tick(1); save_req = 1'b0;
  endtask

  task automatic pulse_nvwr;
    nv_wr = 1'b1; tick(1); nv_wr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(3);
    n_vec++;
    if ({sd_rd, sd_wr, bk_ena, busy, dirty, bk_reset, sd_lba} !== 38'd0) begin
      n_err++; $display("FAIL reset_main: got %h want 0", {sd_rd, sd_wr, bk_ena, busy, dirty, bk_reset, sd_lba});
    end
    n_vec++;
    if ({a_rd, a_wr, a_bk_ena, a_busy, a_dirty, a_bk_reset, a_lba} !== 38'd0) begin
      n_err++; $display("FAIL reset_auto: got %h want 0", {a_rd, a_wr, a_bk_ena, a_busy, a_dirty, a_bk_reset, a_lba});
    end
    reset = 1'b0; tick(2);
  endtask

  task automatic test_ignored;
    clear_log;
    mount(0); pulse_save; tick(20);
    n_vec++;
    if (bk_ena !== 1'b0 || txn_lba.size() != 0) begin
      n_err++; $display("FAIL ignored_req: got bk_ena=%b txns=%0d want 0/0", bk_ena, txn_lba.size());
    end
  endtask

  task automatic test_load_full;
    bit ok;
    int b0;
    rand_ack = 1'b0; clear_log;
    mount(8192); wait_quiet(0, 2000, ok);
    n_vec++;
    if (!ok || txn_lba.size() != 16) begin
      n_err++; $display("FAIL load_full_count: got %0d done=%b want 16", txn_lba.size(), ok);
    end
    for (int i = 0; i < txn_lba.size() && i < 16; i++) begin
      n_vec++;
      if (txn_op[i] != 0 || txn_lba[i] != i) begin
        n_err++; $display("FAIL load_full_seq[%0d]: got op=%0d lba=%0d want op=0 lba=%0d", i, txn_op[i], txn_lba[i], i);
      end
    end
    b0 = (bk_cyc.size() > 0) ? bk_cyc[0] : -1;
    n_vec++;
    if (bk_cyc.size() != 1 || b0 != last_fall + 1) begin
      n_err++; $display("FAIL load_full_bkreset: got %0d pulses at %0d want 1 at %0d", bk_cyc.size(), b0, last_fall + 1);
    end
    n_vec++;
    if (dirty !== 1'b0 || bk_ena !== 1'b1) begin
      n_err++; $display("FAIL load_full_flags: got dirty=%b bk_ena=%b want 0/1", dirty, bk_ena);
    end
  endtask

  task automatic test_load_sizes;
    int fixed[7] = '{1000, 512, 513, 1, 8191, 8193, 100000};
    int unsigned size;
    int exp_n;
    bit ok;
    rand_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      size = (k < 7) ? fixed[k] : $urandom_range(1, 12000);
      exp_n = int'((longint'(size) + 511) / 512);
      if (exp_n > 16) exp_n = 16;
      clear_log;
      if ($urandom_range(0, 1) == 1) pulse_nvwr;
      mount(size); wait_quiet(0, 3000, ok);
      n_vec++;
      if (!ok || txn_lba.size() != exp_n) begin
        n_err++; $display("FAIL load_size_count(%0d): got %0d want %0d", size, txn_lba.size(), exp_n);
      end
      for (int i = 0; i < txn_lba.size() && i < exp_n; i++) begin
        n_vec++;
        if (txn_op[i] != 0 || txn_lba[i] != i) begin
          n_err++; $display("FAIL load_size_seq(%0d)[%0d]: got op=%0d lba=%0d want 0/%0d", size, i, txn_op[i], txn_lba[i], i);
        end
      end
      n_vec++;
      if (bk_cyc.size() != 1 || dirty !== 1'b0) begin
        n_err++; $display("FAIL load_size_end(%0d): got pulses=%0d dirty=%b want 1/0", size, bk_cyc.size(), dirty);
      end
    end
    model_dirty = 1'b0;
  endtask

  task automatic test_save;
    bit ok;
    rand_ack = 1'b0; clear_log;
    pulse_nvwr;
    n_vec++;
    if (dirty !== 1'b1) begin
      n_err++; $display("FAIL save_dirty_set: got %b want 1", dirty);
    end
    pulse_save; wait_quiet(0, 2000, ok);
    n_vec++;
    if (!ok || txn_lba.size() != 16) begin
      n_err++; $display("FAIL save_count: got %0d want 16", txn_lba.size());
    end
    for (int i = 0; i < txn_lba.size() && i < 16; i++) begin
      n_vec++;
      if (txn_op[i] != 1 || txn_lba[i] != i) begin
        n_err++; $display("FAIL save_seq[%0d]: got op=%0d lba=%0d want 1/%0d", i, txn_op[i], txn_lba[i], i);
      end
    end
    n_vec++;
    if (dirty !== 1'b0 || bk_cyc.size() != 0) begin
      n_err++; $display("FAIL save_end: got dirty=%b pulses=%0d want 0/0", dirty, bk_cyc.size());
    end
    clear_log;
    pulse_nvwr; pulse_save;
    wait_count(6, 500, ok);
    pulse_nvwr;
    wait_quiet(0, 2000, ok);
    n_vec++;
    if (txn_lba.size() != 16 || dirty !== 1'b1) begin
      n_err++; $display("FAIL save_midwrite: got txns=%0d dirty=%b want 16/1", txn_lba.size(), dirty);
    end
    tick(150);
    n_vec++;
    if (txn_lba.size() != 16) begin
      n_err++; $display("FAIL no_autosave: got txns=%0d want 16", txn_lba.size());
    end
    model_dirty = 1'b1;
  endtask

  task automatic test_dirty_random;
    int a, b;
    bit ok;
    rand_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      clear_log;
      a = $urandom_range(0, 2);
      for (int j = 0; j < a; j++) begin pulse_nvwr; tick($urandom_range(0, 3)); end
      if (a > 0) model_dirty = 1'b1;
      n_vec++;
      if (dirty !== model_dirty) begin
        n_err++; $display("FAIL dirty_before[%0d]: got %b want %b", k, dirty, model_dirty);
      end
      pulse_save;
      b = $urandom_range(0, 1);
      if (b == 1) begin
        wait_count($urandom_range(1, 15), 500, ok);
        pulse_nvwr;
      end
      wait_quiet(0, 3000, ok);
      model_dirty = (b == 1);
      n_vec++;
      if (txn_lba.size() != 16 || dirty !== model_dirty) begin
        n_err++; $display("FAIL dirty_after[%0d]: got txns=%0d dirty=%b want 16/%b", k, txn_lba.size(), dirty, model_dirty);
      end
    end
  endtask

  task automatic test_same_cycle;
    int exp_op[$];
    int exp_lba[$];
    bit ok;
    rand_ack = 1'b0;
    dl_start = 1'b1; tick(1); dl_start = 1'b0; tick(2);
    n_vec++;
    if (bk_ena !== 1'b0) begin
      n_err++; $display("FAIL dl_disarm: got bk_ena=%b want 0", bk_ena);
    end
    for (int i = 0; i < 16; i++) begin exp_op.push_back(0); exp_lba.push_back(i); end
    for (int i = 0; i < 16; i++) begin exp_op.push_back(1); exp_lba.push_back(i); end
    clear_log;
    img_size = 8192; img_mounted = 1'b1; save_req = 1'b1; tick(1);
    img_mounted = 1'b0; save_req = 1'b0;
    wait_quiet(0, 3000, ok);
    n_vec++;
    if (txn_lba.size() != exp_lba.size() || bk_cyc.size() != 1) begin
      n_err++; $display("FAIL same_cycle_count: got txns=%0d pulses=%0d want 32/1", txn_lba.size(), bk_cyc.size());
    end
    for (int i = 0; i < txn_lba.size() && i < exp_lba.size(); i++) begin
      n_vec++;
      if (txn_op[i] != exp_op[i] || txn_lba[i] != exp_lba[i]) begin
        n_err++; $display("FAIL same_cycle_seq[%0d]: got %0d/%0d want %0d/%0d", i, txn_op[i], txn_lba[i], exp_op[i], exp_lba[i]);
      end
    end
  endtask

  task automatic test_abort_save;
    bit ok;
    rand_ack = 1'b0; clear_log;
    pulse_save;
    wait_count(4, 500, ok);
    for (int i = 0; i < 20; i++) begin
      if (sd_ack) break;
      @(negedge clk_sys);
    end
    dl_start = 1'b1; tick(1); dl_start = 1'b0;
    wait_quiet(0, 500, ok);
    n_vec++;
    if (txn_lba.size() != 4 || bk_ena !== 1'b0 || !ok) begin
      n_err++; $display("FAIL abort_save: got txns=%0d bk_ena=%b want 4/0", txn_lba.size(), bk_ena);
    end
    pulse_save; tick(30);
    n_vec++;
    if (txn_lba.size() != 4 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_save_ignored: got txns=%0d busy=%b want 4/0", txn_lba.size(), busy);
    end
  endtask

  task automatic test_abort_reset;
    bit ok;
    int n_before;
    rand_ack = 1'b0; clear_log;
    mount(8192);
    wait_count(3, 500, ok);
    for (int i = 0; i < 20; i++) begin
      if (sd_rd) break;
      @(negedge clk_sys);
    end
    n_before = txn_lba.size();
    reset = 1'b1; tick(1);
    n_vec++;
    if (sd_rd !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_drop: got sd_rd=%b busy=%b want 0/0", sd_rd, busy);
    end
    tick(1); reset = 1'b0; tick(40);
    n_vec++;
    if (bk_cyc.size() != 0 || bk_ena !== 1'b0 || txn_lba.size() != n_before) begin
      n_err++; $display("FAIL reset_no_bk: got pulses=%0d bk_ena=%b txns=%0d want 0/0/%0d", bk_cyc.size(), bk_ena, txn_lba.size(), n_before);
    end
  endtask

  task automatic test_autosave;
    bit ok;
    int t0, gap, exp_c;
    a_size = 8192; a_mounted = 1'b1; tick(1); a_mounted = 1'b0;
    wait_quiet(1, 1000, ok);
    n_vec++;
    if (a_bk_ena !== 1'b1 || a_dirty !== 1'b0) begin
      n_err++; $display("FAIL auto_mount: got bk_ena=%b dirty=%b want 1/0", a_bk_ena, a_dirty);
    end
    for (int k = 0; k < 3; k++) begin
      gap = (k == 0) ? 0 : (k == 1) ? 50 : $urandom_range(10, 90);
      a_wr_seen = 1'b0;
      a_nvwr = 1'b1; t0 = cyc + 1; tick(1); a_nvwr = 1'b0;
      if (gap > 0) begin
        tick(gap - 1);
        a_nvwr = 1'b1; tick(1); a_nvwr = 1'b0;
      end
      exp_c = t0 + gap + 100;
      for (int i = 0; i < 300 && !a_wr_seen; i++) @(negedge clk_sys);
      n_vec++;
      if (!a_wr_seen || a_wr_cyc < exp_c - 2 || a_wr_cyc > exp_c + 2) begin
        n_err++; $display("FAIL autosave_time(gap %0d): got seen=%b at %0d want %0d+-2", gap, a_wr_seen, a_wr_cyc, exp_c);
      end
      wait_quiet(1, 1000, ok);
      n_vec++;
      if (a_dirty !== 1'b0 || !ok) begin
        n_err++; $display("FAIL autosave_clean(gap %0d): got dirty=%b want 0", gap, a_dirty);
      end
    end
    a_wr_seen = 1'b0; tick(150);
    n_vec++;
    if (a_wr_seen) begin
      n_err++; $display("FAIL autosave_spurious: got write at %0d want none", a_wr_cyc);
    end
  endtask

  task automatic test_exclusive;
    n_vec++;
    if (both_seen) begin
      n_err++; $display("FAIL rd_wr_exclusive: got both high want never");
    end
  endtask

  initial begin
    reset = 1'b1;
    img_mounted = 1'b0; img_size = '0; save_req = 1'b0; dl_start = 1'b0; nv_wr = 1'b0;
    a_mounted = 1'b0; a_size = '0; a_save = 1'b0; a_dl = 1'b0; a_nvwr = 1'b0;
    @(negedge clk_sys);
    test_reset;
    test_ignored;
    test_load_full;
    test_load_sizes;
    test_save;
    test_dirty_random;
    test_same_cycle;
    test_abort_save;
    test_abort_reset;
    test_autosave;
    test_exclusive;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
